// File: rtl/core_l1d_resp_if.sv
// Bundle of the core-side request/response signals and the word-wide
// data-memory bus seen by the L1D responder. The responder uses the slave
// view; the pipeline/memory environment uses the master view.
interface core_l1d_resp_if;
    logic        l1d_req_val;
    logic        l1d_req_cop;
    logic [2:0]  l1d_req_size;
    logic [31:0] l1d_req_addr;
    logic [31:0] l1d_req_wdata;
    logic        l1d_req_rdy;
    logic        l1d_busy;
    logic        l1d_resp_val;
    logic [31:0] l1d_resp_rdata;
    logic        l1d_resp_err;
    logic        mem_req_val;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  l1d_req_val, l1d_req_cop, l1d_req_size, l1d_req_addr, l1d_req_wdata,
        output l1d_req_rdy, l1d_busy, l1d_resp_val, l1d_resp_rdata, l1d_resp_err,
        output mem_req_val, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output l1d_req_val, l1d_req_cop, l1d_req_size, l1d_req_addr, l1d_req_wdata,
        input  l1d_req_rdy, l1d_busy, l1d_resp_val, l1d_resp_rdata, l1d_resp_err,
        input  mem_req_val, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/core_l1d_resp.sv
// Core-side L1D responder. Takes one registered data-memory request from the
// execute stage, checks alignment, runs it on the word bus with byte enables
// and lane-replicated store data, and returns one zero-extended response.
// A bus access that never completes is ended with an error after TIMEOUT
// cycles. Every output comes straight from a register or the state register.
module core_l1d_resp #(
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    core_l1d_resp_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    logic [1:0]      state_q,     state_d;
    logic [TO_W-1:0] cnt_q,       cnt_d;
    logic            cop_q,       cop_d;
    logic [2:0]      size_q,      size_d;
    logic [1:0]      off_q,       off_d;
    logic            err_q,       err_d;
    logic [31:0]     rdata_q,     rdata_d;
    logic            memWe_q,     memWe_d;
    logic [31:0]     memAddr_q,   memAddr_d;
    logic [3:0]      memBe_q,     memBe_d;
    logic [31:0]     memWdata_q,  memWdata_d;

    logic            reqIllegal;
    logic [3:0]      reqBe;
    logic [31:0]     reqWdata;
    logic [31:0]     loadLane;

    // Decode the incoming request: legality, byte enables and replicated store data.
    always_comb begin
        reqIllegal = 1'b0;
        reqBe      = 4'b0000;
        reqWdata   = bus.l1d_req_wdata;
        case (bus.l1d_req_size)
            SZ_BYTE: begin
                reqBe    = 4'b0001 << bus.l1d_req_addr[1:0];
                reqWdata = {4{bus.l1d_req_wdata[7:0]}};
            end
            SZ_HALF: begin
                reqIllegal = bus.l1d_req_addr[0];
                reqBe      = bus.l1d_req_addr[1] ? 4'b1100 : 4'b0011;
                reqWdata   = {2{bus.l1d_req_wdata[15:0]}};
            end
            SZ_WORD: begin
                reqIllegal = (bus.l1d_req_addr[1:0] != 2'b00);
                reqBe      = 4'b1111;
                reqWdata   = bus.l1d_req_wdata;
            end
            default: begin
                reqIllegal = 1'b1;
            end
        endcase
    end

    // Pick the addressed lane out of the returned bus word, zero-extended.
    always_comb begin
        loadLane = bus.mem_rdata;
        case (size_q)
            SZ_BYTE: begin
                case (off_q)
                    2'd0:    loadLane = {24'd0, bus.mem_rdata[7:0]};
                    2'd1:    loadLane = {24'd0, bus.mem_rdata[15:8]};
                    2'd2:    loadLane = {24'd0, bus.mem_rdata[23:16]};
                    default: loadLane = {24'd0, bus.mem_rdata[31:24]};
                endcase
            end
            SZ_HALF: begin
                loadLane = off_q[1] ? {16'd0, bus.mem_rdata[31:16]}
                                    : {16'd0, bus.mem_rdata[15:0]};
            end
            default: begin
                loadLane = bus.mem_rdata;
            end
        endcase
    end

    // Next-state logic: accept in IDLE, wait for ack or timeout in BUS, strobe in RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cop_d      = cop_q;
        size_d     = size_q;
        off_d      = off_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memBe_d    = memBe_q;
        memWdata_d = memWdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.l1d_req_val) begin
                    if (reqIllegal) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = ST_RESP;
                    end else begin
                        cop_d      = bus.l1d_req_cop;
                        size_d     = bus.l1d_req_size;
                        off_d      = bus.l1d_req_addr[1:0];
                        memWe_d    = bus.l1d_req_cop;
                        memAddr_d  = {bus.l1d_req_addr[31:2], 2'b00};
                        memBe_d    = reqBe;
                        memWdata_d = reqWdata;
                        cnt_d      = '0;
                        state_d    = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_ack) begin
                    err_d   = 1'b0;
                    rdata_d = cop_q ? 32'd0 : loadLane;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cop_q      <= 1'b0;
            size_q     <= 3'b000;
            off_q      <= 2'b00;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            memWe_q    <= 1'b0;
            memAddr_q  <= 32'd0;
            memBe_q    <= 4'b0000;
            memWdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cop_q      <= cop_d;
            size_q     <= size_d;
            off_q      <= off_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memBe_q    <= memBe_d;
            memWdata_q <= memWdata_d;
        end
    end

    assign bus.l1d_req_rdy    = (state_q == ST_IDLE);
    assign bus.l1d_busy       = (state_q != ST_IDLE);
    assign bus.l1d_resp_val   = (state_q == ST_RESP);
    assign bus.l1d_resp_rdata = rdata_q;
    assign bus.l1d_resp_err   = err_q;
    assign bus.mem_req_val    = (state_q == ST_BUS);
    assign bus.mem_req_we     = memWe_q;
    assign bus.mem_req_addr   = memAddr_q;
    assign bus.mem_req_be     = memBe_q;
    assign bus.mem_req_wdata  = memWdata_q;

endmodule

// File: tb/tb_core_l1d_resp.sv
// Directed bench for core_l1d_resp: loads and stores of each size, illegal
// requests, bus timeout with and without a last-cycle ack, reset during a
// pending access and stray acks.
module tb_core_l1d_resp;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    core_l1d_resp_if bus ();

    core_l1d_resp #(
        .TIMEOUT(200),
        .TO_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic val, input logic cop, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bus.l1d_req_val   = val;
        bus.l1d_req_cop   = cop;
        bus.l1d_req_size  = size;
        bus.l1d_req_addr  = addr;
        bus.l1d_req_wdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps; every sample is taken 1 unit after a rising edge.
    initial begin
        int reqHigh;
        int respEarly;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        nextCycle();
        nextCycle();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_rdy",     32'(bus.l1d_req_rdy),  32'd1);
        checkOutput("reset_busy",    32'(bus.l1d_busy),     32'd0);
        checkOutput("reset_respval", 32'(bus.l1d_resp_val), 32'd0);
        checkOutput("reset_memval",  32'(bus.mem_req_val),  32'd0);
        checkOutput("reset_be",      32'(bus.mem_req_be),   32'd0);

        $display("[TB] word load at 0x100");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        checkOutput("wl_memval", 32'(bus.mem_req_val), 32'd1);
        checkOutput("wl_addr",   bus.mem_req_addr,     32'h0000_0100);
        checkOutput("wl_be",     32'(bus.mem_req_be),  32'hF);
        checkOutput("wl_we",     32'(bus.mem_req_we),  32'd0);
        checkOutput("wl_busy",   32'(bus.l1d_busy),    32'd1);
        checkOutput("wl_rdy",    32'(bus.l1d_req_rdy), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        nextCycle();
        bus.mem_ack   = 1'b0;
        checkOutput("wl_respval", 32'(bus.l1d_resp_val), 32'd1);
        checkOutput("wl_rdata",   bus.l1d_resp_rdata,    32'hDEAD_BEEF);
        checkOutput("wl_err",     32'(bus.l1d_resp_err), 32'd0);
        checkOutput("wl_memval2", 32'(bus.mem_req_val),  32'd0);
        checkOutput("wl_busy2",   32'(bus.l1d_busy),     32'd1);
        nextCycle();
        checkOutput("wl_respdone", 32'(bus.l1d_resp_val), 32'd0);
        checkOutput("wl_rdyback",  32'(bus.l1d_req_rdy),  32'd1);

        $display("[TB] byte store at 0x203 with 3 wait cycles");
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        checkOutput("bs_be",    32'(bus.mem_req_be),  32'h8);
        checkOutput("bs_wdata", bus.mem_req_wdata,    32'hA5A5_A5A5);
        checkOutput("bs_we",    32'(bus.mem_req_we),  32'd1);
        checkOutput("bs_addr",  bus.mem_req_addr,     32'h0000_0200);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("bs_memval_c4", 32'(bus.mem_req_val),  32'd1);
        checkOutput("bs_noresp_c4", 32'(bus.l1d_resp_val), 32'd0);
        checkOutput("bs_wdata_c4",  bus.mem_req_wdata,     32'hA5A5_A5A5);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        nextCycle();
        bus.mem_ack   = 1'b0;
        checkOutput("bs_respval", 32'(bus.l1d_resp_val), 32'd1);
        checkOutput("bs_rdata",   bus.l1d_resp_rdata,    32'd0);
        checkOutput("bs_err",     32'(bus.l1d_resp_err), 32'd0);
        nextCycle();

        $display("[TB] half load at 0x42");
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0042, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        checkOutput("hl_be", 32'(bus.mem_req_be), 32'hC);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h8001_7FFF;
        nextCycle();
        bus.mem_ack   = 1'b0;
        checkOutput("hl_respval", 32'(bus.l1d_resp_val), 32'd1);
        checkOutput("hl_rdata",   bus.l1d_resp_rdata,    32'h0000_8001);
        checkOutput("hl_err",     32'(bus.l1d_resp_err), 32'd0);
        nextCycle();

        $display("[TB] byte load at 0x201");
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        checkOutput("bl_be", 32'(bus.mem_req_be), 32'h2);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1122_3344;
        nextCycle();
        bus.mem_ack   = 1'b0;
        checkOutput("bl_rdata", bus.l1d_resp_rdata, 32'h0000_0033);
        nextCycle();

        $display("[TB] half store at 0x40");
        applyStimulus(1'b1, 1'b1, 3'b001, 32'h0000_0040, 32'hFFFF_BEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        checkOutput("hs_be",    32'(bus.mem_req_be), 32'h3);
        checkOutput("hs_wdata", bus.mem_req_wdata,   32'hBEEF_BEEF);
        bus.mem_ack = 1'b1;
        nextCycle();
        bus.mem_ack = 1'b0;
        checkOutput("hs_respval", 32'(bus.l1d_resp_val), 32'd1);
        nextCycle();

        $display("[TB] illegal requests");
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0041, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        checkOutput("ih_memval",  32'(bus.mem_req_val),  32'd0);
        checkOutput("ih_respval", 32'(bus.l1d_resp_val), 32'd1);
        checkOutput("ih_err",     32'(bus.l1d_resp_err), 32'd1);
        checkOutput("ih_rdata",   bus.l1d_resp_rdata,    32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        checkOutput("iw_memval", 32'(bus.mem_req_val),  32'd0);
        checkOutput("iw_err",    32'(bus.l1d_resp_err), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 3'b011, 32'h0000_0100, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        checkOutput("is_respval", 32'(bus.l1d_resp_val), 32'd1);
        checkOutput("is_err",     32'(bus.l1d_resp_err), 32'd1);
        nextCycle();

        $display("[TB] word load timeout");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        reqHigh   = 0;
        respEarly = 0;
        for (int c = 1; c <= 200; c++) begin
            if (bus.mem_req_val === 1'b1) reqHigh++;
            if (bus.l1d_resp_val !== 1'b0) respEarly++;
            nextCycle();
        end
        checkOutput("to_reqcycles", 32'(reqHigh),            32'd200);
        checkOutput("to_earlyresp", 32'(respEarly),          32'd0);
        checkOutput("to_respval",   32'(bus.l1d_resp_val),   32'd1);
        checkOutput("to_err",       32'(bus.l1d_resp_err),   32'd1);
        checkOutput("to_rdata",     bus.l1d_resp_rdata,      32'd0);
        checkOutput("to_memval",    32'(bus.mem_req_val),    32'd0);
        nextCycle();

        $display("[TB] word load with ack in the timeout cycle");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        for (int c = 1; c < 200; c++) begin
            nextCycle();
        end
        checkOutput("ta_memval_c200", 32'(bus.mem_req_val), 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        nextCycle();
        bus.mem_ack   = 1'b0;
        checkOutput("ta_respval", 32'(bus.l1d_resp_val), 32'd1);
        checkOutput("ta_err",     32'(bus.l1d_resp_err), 32'd0);
        checkOutput("ta_rdata",   bus.l1d_resp_rdata,    32'hCAFE_F00D);
        nextCycle();

        $display("[TB] reset during a pending load");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("rb_memval",  32'(bus.mem_req_val),  32'd0);
        checkOutput("rb_respval", 32'(bus.l1d_resp_val), 32'd0);
        checkOutput("rb_rdy",     32'(bus.l1d_req_rdy),  32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        nextCycle();
        bus.mem_ack   = 1'b0;
        checkOutput("rb_stray_respval", 32'(bus.l1d_resp_val), 32'd0);
        checkOutput("rb_stray_rdy",     32'(bus.l1d_req_rdy),  32'd1);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0503, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        checkOutput("rb_next_be", 32'(bus.mem_req_be), 32'h8);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hF1E2_D3C4;
        nextCycle();
        bus.mem_ack   = 1'b0;
        checkOutput("rb_next_respval", 32'(bus.l1d_resp_val), 32'd1);
        checkOutput("rb_next_rdata",   bus.l1d_resp_rdata,    32'h0000_00F1);
        nextCycle();

        $display("[TB] spurious ack in IDLE");
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_0BAD;
        nextCycle();
        bus.mem_ack   = 1'b0;
        checkOutput("sp_respval", 32'(bus.l1d_resp_val), 32'd0);
        checkOutput("sp_busy",    32'(bus.l1d_busy),     32'd0);
        nextCycle();
        checkOutput("sp_respval2", 32'(bus.l1d_resp_val), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
